// File: rtl/fp_pkg.sv
// Shared binary64 constants, FSM encoding and packing helper for the FP converters.
package fp_pkg;

   localparam int DP_EXP_W  = 11;
   localparam int DP_FRAC_W = 52;
   localparam int DP_BIAS   = 1023;

   // Exponent of a normalised 64-bit integer with no leading zeros (bit 63 set).
   localparam logic [DP_EXP_W-1:0] INT_EXP_BASE = DP_EXP_W'(DP_BIAS + 63);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      RND  = 2'd2,
      OUT  = 2'd3
   } int2fp_state_t;

   function automatic logic [63:0] dp_pack(input logic                 sign,
                                           input logic [DP_EXP_W-1:0]  exp,
                                           input logic [DP_FRAC_W-1:0] frac);
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/int_to_fp_seq_if.sv
// Producer/consumer handshake bundle for the integer-to-binary64 converter.
interface int_to_fp_seq_if;

   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_int;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_fp;
   logic        out_inexact;

   modport master (
      output in_valid, in_int, out_ready,
      input  in_ready, out_valid, out_fp, out_inexact
   );

   modport slave (
      input  in_valid, in_int, out_ready,
      output in_ready, out_valid, out_fp, out_inexact
   );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 52-bit fraction with guard/sticky; carry-out bumps the exponent.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [DP_FRAC_W-1:0] frac_i,
   input  logic                 guard_i,
   input  logic                 sticky_i,
   input  logic [DP_EXP_W-1:0]  exp_i,
   output logic [DP_FRAC_W-1:0] frac_o,
   output logic [DP_EXP_W-1:0]  exp_o,
   output logic                 inexact_o
);

   logic               round_up;
   logic [DP_FRAC_W:0] sum;

   // Increment on guard when above half or on a tie with an odd fraction.
   always_comb begin
      round_up  = guard_i & (sticky_i | frac_i[0]);
      sum       = {1'b0, frac_i} + {{DP_FRAC_W{1'b0}}, round_up};
      // On carry-out the low bits are already all zero.
      frac_o    = sum[DP_FRAC_W-1:0];
      exp_o     = exp_i + {{(DP_EXP_W-1){1'b0}}, sum[DP_FRAC_W]};
      inexact_o = guard_i | sticky_i;
   end

endmodule

// File: rtl/int_to_fp_seq.sv
// Multi-cycle 64-bit integer to binary64 converter, fixed 7-edge latency.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | six binary-search shift steps (32,16,8,4,2,1)
// RND   | round, pack and present the result
// OUT   | result held until the consumer takes it
module int_to_fp_seq
   import fp_pkg::*;
#(
   parameter bit SIGNED_MODE = 1'b1
)(
   input  logic            clk,
   input  logic            rst_n,
   int_to_fp_seq_if.slave  bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_NORM = NORM;
   localparam logic [1:0] S_RND  = RND;
   localparam logic [1:0] S_OUT  = OUT;

   logic [1:0]  state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [63:0] mag_q, mag_d;
   logic [5:0]  shamt_q, shamt_d;
   logic        sign_q, sign_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [63:0] out_fp_q, out_fp_d;
   logic        out_inexact_q, out_inexact_d;

   logic                 top_zero;
   logic [5:0]           nrm_w;
   logic [DP_FRAC_W-1:0] rnd_frac;
   logic [DP_EXP_W-1:0]  rnd_exp;
   logic                 rnd_inexact;

   // Is the top 2^step bits of the magnitude all zero?
   always_comb begin
      nrm_w = 6'd1 << step_q;
      case (step_q)
         3'd5:    top_zero = ~|mag_q[63:32];
         3'd4:    top_zero = ~|mag_q[63:48];
         3'd3:    top_zero = ~|mag_q[63:56];
         3'd2:    top_zero = ~|mag_q[63:60];
         3'd1:    top_zero = ~|mag_q[63:62];
         default: top_zero = ~mag_q[63];
      endcase
   end

   fp_round_rne u_round (
      .frac_i    (mag_q[62:11]),
      .guard_i   (mag_q[10]),
      .sticky_i  (|mag_q[9:0]),
      .exp_i     (INT_EXP_BASE - {5'd0, shamt_q}),
      .frac_o    (rnd_frac),
      .exp_o     (rnd_exp),
      .inexact_o (rnd_inexact)
   );

   // Next-state logic for the sequencer and the datapath registers.
   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      mag_d         = mag_q;
      shamt_d       = shamt_q;
      sign_d        = sign_q;
      in_ready_d    = in_ready_q;
      out_valid_d   = out_valid_q;
      out_fp_d      = out_fp_q;
      out_inexact_d = out_inexact_q;
      case (state_q)
         S_IDLE: begin
            in_ready_d = 1'b1;
            if (bus.in_valid && in_ready_q) begin
               sign_d     = SIGNED_MODE & bus.in_int[63];
               mag_d      = sign_d ? (~bus.in_int + 64'd1) : bus.in_int;
               shamt_d    = 6'd0;
               step_d     = 3'd5;
               in_ready_d = 1'b0;
               state_d    = S_NORM;
            end
         end
         S_NORM: begin
            if (top_zero) begin
               mag_d   = mag_q << nrm_w;
               shamt_d = shamt_q + nrm_w;
            end
            if (step_q == 3'd0) state_d = S_RND;
            else                step_d  = step_q - 3'd1;
         end
         S_RND: begin
            // Zero normalises to nothing; emit +0 regardless of sign mode.
            if (mag_q == 64'd0) begin
               out_fp_d      = 64'd0;
               out_inexact_d = 1'b0;
            end else begin
               out_fp_d      = dp_pack(sign_q, rnd_exp, rnd_frac);
               out_inexact_d = rnd_inexact;
            end
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         step_q        <= 3'd0;
         mag_q         <= 64'd0;
         shamt_q       <= 6'd0;
         sign_q        <= 1'b0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_fp_q      <= 64'd0;
         out_inexact_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         mag_q         <= mag_d;
         shamt_q       <= shamt_d;
         sign_q        <= sign_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         out_fp_q      <= out_fp_d;
         out_inexact_q <= out_inexact_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_fp      = out_fp_q;
   assign bus.out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed bench: a signed and an unsigned converter driven in lockstep.
module tb_int_to_fp_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_int;
   logic        out_ready;
   int          n_checks;
   int          n_err;

   int_to_fp_seq_if ifs ();
   int_to_fp_seq_if ifu ();

   assign ifs.in_valid  = in_valid;
   assign ifs.in_int    = in_int;
   assign ifs.out_ready = out_ready;
   assign ifu.in_valid  = in_valid;
   assign ifu.in_int    = in_int;
   assign ifu.out_ready = out_ready;

   int_to_fp_seq #(.SIGNED_MODE(1'b1)) u_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));
   int_to_fp_seq #(.SIGNED_MODE(1'b0)) u_u (.clk(clk), .rst_n(rst_n), .bus(ifu.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [63:0] v);
      int n;
      n = 0;
      while (!(ifs.in_ready && ifu.in_ready) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 64'(n < 30), 64'd1);
      @(negedge clk);
      in_valid = 1'b1;
      in_int   = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ifs.out_valid && n < 20);
   endtask

   task automatic run_op(input string tag, input logic [63:0] v,
                         input logic [63:0] es, input logic is_,
                         input logic [63:0] eu, input logic iu);
      int n;
      accept(v);
      wait_out(n);
      chk({tag, "_lat"}, 64'(n), 64'd7);
      chk({tag, "_u_valid"}, 64'(ifu.out_valid), 64'd1);
      chk({tag, "_s_fp"}, ifs.out_fp, es);
      chk({tag, "_s_inx"}, 64'(ifs.out_inexact), 64'(is_));
      chk({tag, "_u_fp"}, ifu.out_fp, eu);
      chk({tag, "_u_inx"}, 64'(ifu.out_inexact), 64'(iu));
      @(posedge clk);
      #1;
      chk({tag, "_drop"}, 64'(ifs.out_valid), 64'd0);
   endtask

   initial begin
      int n;
      logic seen;
      n_checks  = 0;
      n_err     = 0;
      in_valid  = 1'b0;
      in_int    = 64'd0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      chk("rst_in_ready", 64'(ifs.in_ready), 64'd0);
      chk("rst_out_valid", 64'(ifs.out_valid), 64'd0);
      chk("rst_out_fp", ifs.out_fp, 64'd0);
      chk("rst_inexact", 64'(ifs.out_inexact), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_low", 64'(ifs.in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("rel_in_ready_high", 64'(ifs.in_ready), 64'd1);

      run_op("one",  64'd1,                 64'h3FF0000000000000, 1'b0, 64'h3FF0000000000000, 1'b0);
      run_op("m1",   64'hFFFFFFFFFFFFFFFF,  64'hBFF0000000000000, 1'b0, 64'h43F0000000000000, 1'b1);
      run_op("zero", 64'd0,                 64'h0000000000000000, 1'b0, 64'h0000000000000000, 1'b0);
      run_op("tie_even", 64'h0020000000000001, 64'h4340000000000000, 1'b1, 64'h4340000000000000, 1'b1);
      run_op("tie_up",   64'h0020000000000003, 64'h4340000000000002, 1'b1, 64'h4340000000000002, 1'b1);
      run_op("maxpos",   64'h7FFFFFFFFFFFFFFF, 64'h43E0000000000000, 1'b1, 64'h43E0000000000000, 1'b1);
      run_op("minneg",   64'h8000000000000000, 64'hC3E0000000000000, 1'b0, 64'h43E0000000000000, 1'b0);
      run_op("f000",     64'hF000000000000000, 64'hC3B0000000000000, 1'b0, 64'h43EE000000000000, 1'b0);

      // Backpressure with a second request waiting.
      out_ready = 1'b0;
      accept(64'd5);
      wait_out(n);
      chk("bp_lat", 64'(n), 64'd7);
      in_valid = 1'b1;
      in_int   = 64'd1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("bp_fp", ifs.out_fp, 64'h4014000000000000);
         chk("bp_valid", 64'(ifs.out_valid), 64'd1);
         chk("bp_in_ready", 64'(ifs.in_ready), 64'd0);
      end
      chk("bp_u_fp", ifu.out_fp, 64'h4014000000000000);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hs_valid", 64'(ifs.out_valid), 64'd0);
      chk("bp_hs_ready", 64'(ifs.in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_second_taken", 64'(ifs.in_ready), 64'd0);
      wait_out(n);
      chk("bp_second_lat", 64'(n), 64'd7);
      chk("bp_second_fp", ifs.out_fp, 64'h3FF0000000000000);
      @(posedge clk);
      #1;

      // Reset during normalisation.
      accept(64'hF000000000000000);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(ifs.out_valid | ifu.out_valid), 64'd0);
      chk("mid_rst_ready", 64'(ifs.in_ready | ifu.in_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_ready_low", 64'(ifs.in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("mid_rel_ready_high", 64'(ifs.in_ready), 64'd1);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (ifs.out_valid || ifu.out_valid) seen = 1'b1;
      end
      chk("no_stale", 64'(seen), 64'd0);
      run_op("post_rst", 64'd5, 64'h4014000000000000, 1'b0, 64'h4014000000000000, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
